// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and select encodings for the multi-cycle MIPS control
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_out_decode.sv
// rtl/mc_out_decode.sv - combinational map from current state to datapath control outputs
module mc_out_decode
    import mc_pkg::*;
(
    input  state_e      state,
    input  logic        memReady,
    input  logic        rst,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        iorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        memToReg,
    output logic        regDst,
    output logic        regWrite,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic [1:0]  pcSource,
    output logic        instrDone
);

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_B;
        aluOp       = ALU_ADD;
        pcSource    = PCSRC_ALU;
        instrDone   = 1'b0;

        case (state)
            S_FETCH: begin
                memRead = 1'b1;
                irWrite = memReady;
                pcWrite = memReady;
                aluSrcB = SRCB_FOUR;
            end
            S_DECODE: aluSrcB = SRCB_IMM_SH2;
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWR: begin
                memWrite  = 1'b1;
                iorD      = 1'b1;
                instrDone = memReady;
            end
            S_MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
            end
            S_ADDIWB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALU_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
                instrDone   = 1'b1;
            end
            S_JUMP: begin
                pcWrite   = 1'b1;
                pcSource  = PCSRC_JUMP;
                instrDone = 1'b1;
            end
            default: ;
        endcase

        // Reset suppresses every strobe so an interrupted instruction never commits
        if (rst) begin
            regWrite    = 1'b0;
            memWrite    = 1'b0;
            memRead     = 1'b0;
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            irWrite     = 1'b0;
            instrDone   = 1'b0;
        end
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS main control FSM with sticky illegal-opcode flag
module mc_control
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               memToReg,
    output logic               regDst,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic [1:0]         pcSource,
    output logic               instrDone,
    output logic               illegalOp,
    output logic [STATE_W-1:0] state
);

    state_e state_q;
    state_e state_d;
    logic   illegal_q;
    logic   set_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:   state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = memReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            // Write-back/terminal states and unused codes 12-15 all return to FETCH
            default:   state_d = S_FETCH;
        endcase
    end

    assign illegalOp = illegal_q;
    assign state     = STATE_W'(state_q);

    mc_out_decode u_out_decode (
        .state       (state_q),
        .memReady    (memReady),
        .rst         (rst),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memToReg    (memToReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .pcSource    (pcSource),
        .instrDone   (instrDone)
    );

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle MIPS main control FSM that sequences the shared datapath: PC, instruction register, unified memory port, ALU and the 32x32 register file.
- Decodes the 6-bit opcode from the instruction register.
- Drives all datapath mux selects and write strobes, including the register file `regWrite` strobe.
- Waits on a memory-ready handshake and flags unsupported opcodes.

Parameters:
- STATE_W, 4, width of the state register and debug state output.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- op  input  6  opcode, instr[31:26] from the instruction register.
- memReady  input  1  memory handshake: access completes in any cycle it is high.
- pcWrite  output  1  unconditional PC load.
- pcWriteCond  output  1  PC load if ALU zero (beq).
- iorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  output  1  memory read request.
- memWrite  output  1  memory write request.
- irWrite  output  1  instruction register load.
- memToReg  output  1  register file write data select: 0 = ALUOut, 1 = MDR.
- regDst  output  1  register file write register select: 0 = rt, 1 = rd.
- regWrite  output  1  register file write enable.
- aluSrcA  output  1  ALU A select: 0 = PC, 1 = A register.
- aluSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- aluOp  output  2  ALU operation class: 00 = add, 01 = sub, 10 = funct.
- pcSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instrDone  output  1  one-cycle pulse in the final state of each instruction.
- illegalOp  output  1  sticky flag, set on an unsupported opcode.
- state  output  STATE_W  current state (debug).

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH on the next edge.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- Transitions:
  - FETCH -> DECODE when memReady=1; otherwise hold FETCH.
  - DECODE: lw/sw -> MEMADR; R -> EXECUTE; beq -> BRANCH; j -> JUMP; addi -> ADDIEX; any other opcode -> FETCH and set illegalOp.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB when memReady=1; otherwise hold.
  - MEMWR -> FETCH when memReady=1; otherwise hold.
  - EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, ALUWB, BRANCH, JUMP, ADDIWB -> FETCH.
- Outputs are decoded from the current state (Moore), except irWrite and pcWrite in FETCH, which equal memReady. Any output not listed for a state is 0.
  - FETCH: memRead=1, iorD=0, irWrite=memReady, pcWrite=memReady, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - DECODE: aluSrcA=0, aluSrcB=11, aluOp=00.
  - MEMADR, ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00.
  - MEMRD: memRead=1, iorD=1.
  - MEMWR: memWrite=1, iorD=1; held until memReady.
  - MEMWB: regWrite=1, memToReg=1, regDst=0.
  - EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10.
  - ALUWB: regWrite=1, regDst=1, memToReg=0.
  - ADDIWB: regWrite=1, regDst=0, memToReg=0.
  - BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01.
  - JUMP: pcWrite=1, pcSource=10.
- instrDone=1 in MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, and in MEMWR when memReady=1.
- Latency with memReady held at 1: R=4, lw=5, sw=4, addi=4, beq=3, j=3 cycles.
- Each cycle memReady is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset:
  - While rst=1, regWrite, memWrite, memRead, pcWrite, pcWriteCond, irWrite and instrDone are forced 0.
  - On the first edge with rst=1, state=FETCH and illegalOp=0.
  - This applies mid-instruction too: no partial write completes.
- illegalOp stays 1 until reset. Execution continues after it is set; the offending instruction takes 2 cycles (FETCH, DECODE) and does not pulse instrDone.
- op is sampled only in DECODE and MEMADR; its value in other states is don't-care.

Decomposition:
- Package mc_pkg holds:
  - the state enum/localparams;
  - opcode constants;
  - aluOp constants;
  - aluSrcB and pcSource select constants.
- One sub-module, mc_out_decode: a purely combinational map from (state, memReady, rst) to all control outputs.
- mc_control keeps the state register, next-state logic and the illegalOp flag.

Test Plan:
- Reset then lw (op=100011), memReady=1 -> state sequence 0,1,2,3,4,0; regWrite=1 and memToReg=1 only in state 4; instrDone pulses once, 5 cycles after fetch start.
- sw (op=101011), memReady low for 3 cycles in MEMWR -> memWrite=1 and iorD=1 for 4 cycles; instrDone only in the cycle memReady=1; then FETCH.
- R-type (op=0) then beq (op=000100), memReady=1 -> ALUWB has regDst=1 and regWrite=1; BRANCH has pcWriteCond=1, aluOp=01, pcSource=01; totals 4 + 3 cycles.
- FETCH with memReady=0 for 2 cycles -> memRead=1 throughout; irWrite and pcWrite stay 0 until the memReady=1 cycle, then state=1.
- op=111111 in DECODE -> next state 0, illegalOp=1 and stays 1 through a following addi (4 cycles, ADDIWB regWrite=1); clears only on rst.
- rst asserted in MEMWB -> regWrite=0 in that cycle, state=0 next cycle, illegalOp=0.
